// File: rtl/zap_sync_fifo_lvl.sv
// zap_sync_fifo_lvl
//   Single-clock FIFO for ZAP core-side queues. It reports occupancy,
//   raises programmable almost-full and almost-empty flags, supports a
//   synchronous flush, and keeps sticky overflow and underflow flags that
//   software can read.
//   FWFT = 1 shows the head word on o_data without a read.
//   FWFT = 0 loads o_data on the edge that accepts a read.
//
// Ports
//   i_clk, i_reset      rising-edge clock, async active-high reset
//   i_flush             synchronous clear of contents (memory untouched)
//   i_clr_err           synchronous clear of the sticky error flags
//   i_wr_en, i_data     write request and data
//   i_ack               read/pop request
//   o_data              read data
//   o_empty/o_empty_n   empty flag and complement
//   o_full/o_full_n     full flag and complement
//   o_count             occupancy, 0..DEPTH
//   o_almost_full       count >= AF_LVL
//   o_almost_empty      count <= AE_LVL
//   o_overflow          sticky: write attempted while full
//   o_underflow         sticky: read attempted while empty
module zap_sync_fifo_lvl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int FWFT   = 1,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_clr_err,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_ack,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_empty_n,
  output logic                   o_full,
  output logic                   o_full_n,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_almost_full,
  output logic                   o_almost_empty,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LVL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic          empty, full;
  logic          wr_acc, rd_acc, ov_set, uf_set, bypass;
  logic [AW-1:0] rd_addr;

  // Accept decisions use the registered flags. Flush discards both
  // requests and suppresses the error events.
  // The pointers carry an extra wrap bit. Equal pointers mean empty.
  // Equal index bits with different wrap bits mean full.
  always_comb begin
    wr_acc = i_wr_en && !full && !i_flush;
    rd_acc = i_ack && !empty && !i_flush;
    ov_set = i_wr_en && full && !i_flush;
    uf_set = i_ack && empty && !i_flush;
    if (i_flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      wr_ptr_nxt = wr_ptr + PW'(wr_acc);
      rd_ptr_nxt = rd_ptr + PW'(rd_acc);
      count_nxt  = count + PW'(wr_acc) - PW'(rd_acc);
    end
    // The FWFT head for next cycle lives at rd_ptr_nxt. If that slot is
    // being written this cycle, the RAM read would return stale data, so
    // the write data is forwarded instead.
    rd_addr = rd_ptr_nxt[AW-1:0];
    bypass  = wr_acc && (wr_ptr[AW-1:0] == rd_addr);
  end

  // Pointers, occupancy and all status flags are registered from the
  // same next-state values. This keeps them mutually consistent every cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      empty          <= 1'b1;
      full           <= 1'b0;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      count          <= count_nxt;
      empty          <= (wr_ptr_nxt == rd_ptr_nxt);
      full           <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                        (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
      o_almost_full  <= (count_nxt >= AF_THR);
      o_almost_empty <= (count_nxt <= AE_THR);
    end
  end

  // Sticky error flags. A set event beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (ov_set)
        o_overflow <= 1'b1;
      else if (i_clr_err)
        o_overflow <= 1'b0;
      if (uf_set)
        o_underflow <= 1'b1;
      else if (i_clr_err)
        o_underflow <= 1'b0;
    end
  end

  // Storage array. It has no reset, so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= i_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Track the next head every cycle, so the word is ready as soon as
      // o_empty_n rises or a pop advances the read pointer.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
          o_data <= '0;
        else if (bypass)
          o_data <= i_data;
        else
          o_data <= mem[rd_addr];
      end
    end else begin : g_reg
      // Registered read: load the popped head and hold it otherwise.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
          o_data <= '0;
        else if (rd_acc)
          o_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  endgenerate

  assign o_empty   = empty;
  assign o_empty_n = ~empty;
  assign o_full    = full;
  assign o_full_n  = ~full;
  assign o_count   = count;

endmodule

// File: tb/tb_zap_sync_fifo_lvl.sv
// tb_zap_sync_fifo_lvl
//   Drives one FWFT and one registered-read instance with identical
//   stimulus. A queue holds the words written but not yet popped, and
//   sticky-flag variables plus the last popped word give the expected
//   outputs of both instances after every clock edge.
module tb_zap_sync_fifo_lvl;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int AF_LVL = 3;
  localparam int AE_LVL = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             clr_err = 1'b0;
  logic             wr_en = 1'b0;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] wdata = '0;

  logic [WIDTH-1:0] f_data, r_data;
  logic             f_empty, f_empty_n, f_full, f_full_n, f_af, f_ae, f_ov, f_uf;
  logic             r_empty, r_empty_n, r_full, r_full_n, r_af, r_ae, r_ov, r_uf;
  logic [2:0]       f_count, r_count;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [WIDTH-1:0] mdl_q[$];
  logic             mdl_ov = 1'b0;
  logic             mdl_uf = 1'b0;
  logic [WIDTH-1:0] mdl_reg_data = '0;

  always #5 clk = ~clk;

  zap_sync_fifo_lvl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
  ) dut_fwft (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_clr_err(clr_err),
    .i_wr_en(wr_en), .i_data(wdata), .i_ack(ack), .o_data(f_data),
    .o_empty(f_empty), .o_empty_n(f_empty_n), .o_full(f_full), .o_full_n(f_full_n),
    .o_count(f_count), .o_almost_full(f_af), .o_almost_empty(f_ae),
    .o_overflow(f_ov), .o_underflow(f_uf)
  );

  zap_sync_fifo_lvl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)
  ) dut_reg (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_clr_err(clr_err),
    .i_wr_en(wr_en), .i_data(wdata), .i_ack(ack), .o_data(r_data),
    .o_empty(r_empty), .o_empty_n(r_empty_n), .o_full(r_full), .o_full_n(r_full_n),
    .o_count(r_count), .o_almost_full(r_af), .o_almost_empty(r_ae),
    .o_overflow(r_ov), .o_underflow(r_uf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Status vector: {empty, empty_n, full, full_n, almost_full, almost_empty,
  // overflow, underflow, count}.
  task automatic checkAll(input string phase);
    int         n;
    logic [10:0] exp_st;
    n = mdl_q.size();
    exp_st = {n == 0, n != 0, n == DEPTH, n != DEPTH, n >= AF_LVL, n <= AE_LVL,
              mdl_ov, mdl_uf, 3'(n)};
    checkOutput({phase, "/status_fwft"}, 32'({f_empty, f_empty_n, f_full, f_full_n,
                f_af, f_ae, f_ov, f_uf, f_count}), 32'(exp_st));
    checkOutput({phase, "/status_reg"}, 32'({r_empty, r_empty_n, r_full, r_full_n,
                r_af, r_ae, r_ov, r_uf, r_count}), 32'(exp_st));
    if (n > 0)
      checkOutput({phase, "/fwft_head"}, 32'(f_data), 32'(mdl_q[0]));
    checkOutput({phase, "/reg_data"}, 32'(r_data), 32'(mdl_reg_data));
  endtask

  task automatic checkResetValues(input string phase);
    mdl_q.delete();
    mdl_ov       = 1'b0;
    mdl_uf       = 1'b0;
    mdl_reg_data = '0;
    checkAll(phase);
    checkOutput({phase, "/fwft_data"}, 32'(f_data), 32'h0);
  endtask

  // Drive one cycle of requests, let the edge happen, update the expected
  // state from the pre-edge occupancy, then compare.
  task automatic applyStimulus(input logic wr, input logic [WIDTH-1:0] d,
                               input logic a, input logic fl, input logic clr,
                               input string phase);
    int   n;
    logic was_full, was_empty;
    wr_en   = wr;
    wdata   = d;
    ack     = a;
    flush   = fl;
    clr_err = clr;
    n         = mdl_q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    @(posedge clk);
    #1;
    if (!fl && wr && was_full)
      mdl_ov = 1'b1;
    else if (clr)
      mdl_ov = 1'b0;
    if (!fl && a && was_empty)
      mdl_uf = 1'b1;
    else if (clr)
      mdl_uf = 1'b0;
    if (fl) begin
      mdl_q.delete();
    end else begin
      if (a && !was_empty)
        mdl_reg_data = mdl_q.pop_front();
      if (wr && !was_full)
        mdl_q.push_back(d);
    end
    checkAll(phase);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 checkResetValues("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill 0xA0..0xA3, then a fifth write while full.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, "fill");
      checkOutput("fill_count", 32'(f_count), 32'(i + 1));
    end
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, "overflow");
    checkOutput("overflow_flag", 32'(f_ov), 32'h1);

    // FWFT drain: the head is visible before each pop.
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_head", 32'(f_data), 32'hA0 + 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
    end
    checkOutput("drain_reg_last", 32'(r_data), 32'hA3);
    checkOutput("drain_empty", 32'(f_empty), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "underflow");
    checkOutput("underflow_flag", 32'(f_uf), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_both");

    // Write and read together at count 1. The next head is always the
    // word being written.
    applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, "bypass_seed");
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b1, 1'b0, 1'b0, "bypass_stream");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "bypass_drain");

    // Write and read together at count 2 across several pointer wraps.
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, "simul_seed");
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, "simul_seed");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0, "simul");
      checkOutput("simul_count", 32'(f_count), 32'h2);
    end
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, "simul_fill");
    applyStimulus(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, "simul_fill");
    applyStimulus(1'b1, 8'hF2, 1'b1, 1'b0, 1'b0, "full_both");
    checkOutput("full_both_count", 32'(f_count), 32'h3);
    checkOutput("full_both_ov", 32'(f_ov), 32'h1);

    // Flush beats the write and the read in the same cycle and leaves the
    // sticky flags alone.
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, "flush");
    checkOutput("flush_count", 32'(f_count), 32'h0);
    checkOutput("flush_ov_kept", 32'(f_ov), 32'h1);
    checkOutput("flush_uf_kept", 32'(f_uf), 32'h0);

    // Write into an empty FIFO: data is visible one cycle later.
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, "bypass_55");
    checkOutput("bypass_55_empty_n", 32'(f_empty_n), 32'h1);
    checkOutput("bypass_55_fwft", 32'(f_data), 32'h55);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_55");
    checkOutput("pop_55_reg", 32'(r_data), 32'h55);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "write_77");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_77");
    checkOutput("pop_77_reg", 32'(r_data), 32'h77);

    // A clear in the same cycle as an overflow loses to the set. A clear
    // on its own then takes effect.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0, "err_fill");
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, "clr_vs_set");
    checkOutput("clr_vs_set_ov", 32'(f_ov), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_alone");
    checkOutput("clr_alone_ov", 32'(f_ov), 32'h0);

    // Random traffic with occasional flushes and clears.
    for (int i = 0; i < 80; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0), "random");

    // Asynchronous reset between edges with data held.
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, "pre_reset");
    applyStimulus(1'b1, 8'h32, 1'b1, 1'b0, 1'b0, "pre_reset");
    wr_en = 1'b0;
    ack   = 1'b0;
    #2 reset = 1'b1;
    #1 checkResetValues("async_reset");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, "resume");
    checkOutput("resume_fwft", 32'(f_data), 32'h42);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "resume_pop");
    checkOutput("resume_reg", 32'(r_data), 32'h42);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/zap_sync_fifo_lvl.md
# zap_sync_fifo_lvl

Synchronous single-clock FIFO with occupancy reporting, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. It supports both first-word-fall-through (FWFT) and registered-read modes. It is the next-generation buffer for ZAP core-side queues such as the store buffer, the writeback queue and the instruction prefetch queue, where producers must throttle early and software-visible error state is required.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 32: number of entries; power of two, ≥ 2.
- FWFT, 1: 1 = head word presented on o_data without a read; 0 = registered read.
- AF_LVL, DEPTH-2: o_almost_full asserts when count ≥ AF_LVL; range 1..DEPTH.
- AE_LVL, 2: o_almost_empty asserts when count ≤ AE_LVL; range 0..DEPTH-1.
- i_clk  in  1  core clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous clear of FIFO contents.
- i_clr_err  in  1  synchronous clear of the sticky error flags.
- i_wr_en  in  1  write request.
- i_data  in  WIDTH  write data.
- i_ack  in  1  read/pop request.
- o_data  out  WIDTH  read data.
- o_empty / o_empty_n  out  1  empty flag and its complement.
- o_full / o_full_n  out  1  full flag and its complement.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_almost_full, o_almost_empty  out  1  threshold flags.
- o_overflow, o_underflow  out  1  sticky error flags.

## Operation
- Pointers are $clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit.
  - Empty: the pointers are equal.
  - Full: the index bits are equal and the wrap bits differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- A write is accepted iff i_wr_en && !o_full. A read is accepted iff i_ack && !o_empty. Both decisions use the registered flags from the start of the cycle.
- When full and both i_wr_en and i_ack are high, only the read is accepted. The write is dropped and o_overflow is set.
- When empty and both are high, only the write is accepted. o_underflow is set.
- When neither full nor empty and both are high, both are accepted and the count is unchanged.
- Count update:
  - count_nxt = count + wr_acc − rd_acc.
  - The arithmetic is $clog2(DEPTH)+1 bits wide and never exceeds DEPTH.
  - All status outputs are registered from count_nxt and pointer_nxt, so they are mutually consistent in every cycle.
- Error flags:
  - o_overflow sets on i_wr_en && o_full. o_underflow sets on i_ack && o_empty.
  - Both are cleared only by i_reset or i_clr_err.
  - If a set event and i_clr_err occur in the same cycle, the set wins.
- Flush:
  - i_flush resets both pointers to 0, the count to 0 and the flags to the empty state on the next edge.
  - Flush has priority over i_wr_en and i_ack in the same cycle. Both are discarded and raise no error flags.
  - Memory contents are not cleared. Sticky error flags are unaffected.
- FWFT = 1:
  - o_data equals the head entry whenever o_empty_n = 1. An accepted i_ack advances to the next entry.
  - A write into an empty FIFO (or into the slot being read next) is bypassed through a register so that the data is valid when o_empty_n rises.
  - o_data is don't-care while o_empty = 1.
- FWFT = 0:
  - o_data loads the head entry on the edge following an accepted read and holds otherwise.
- Storage is an inferred synchronous-read block RAM.

## Timing
- Reset values:
  - o_empty = 1, o_empty_n = 0.
  - o_full = 0, o_full_n = 1.
  - o_count = 0.
  - o_almost_empty = 1, o_almost_full = 0.
  - o_overflow = 0, o_underflow = 0.
  - o_data = 0.
  - Pointers = 0.
- Reset mid-operation forces all of the above immediately and asynchronously. Operation resumes on the first edge after release.
- Write to visibility latency is 1 cycle: o_count, o_empty_n and (if FWFT) o_data update on the edge after the write.
- FWFT = 1 read latency: the next head word is valid one cycle after the accepted i_ack.
- FWFT = 0 read latency: o_data is valid one cycle after the accepted i_ack.
- Throughput: one write and one read per cycle sustained.
- o_full rises on the edge of the write that makes count = DEPTH. It falls on the edge after the first accepted read.
- The threshold flags track o_count with zero additional latency.

## Test plan
- **Reset and fill (DEPTH = 4, AF_LVL = 3, AE_LVL = 1).**
  - Stimulus: reset, then write 0xA0..0xA3 on four consecutive cycles.
  - Required: o_count steps 1, 2, 3, 4. o_almost_empty drops once count = 2. o_almost_full rises at count = 3. o_full rises at count = 4.
  - Required: a fifth write sets o_overflow, and the data is not stored.
- **FWFT drain.**
  - Stimulus: with 0xA0..0xA3 stored, hold i_ack high for four cycles.
  - Required: o_data reads 0xA0, 0xA1, 0xA2, 0xA3. o_empty = 1 after the fourth pop.
  - Required: a further i_ack sets o_underflow.
- **Simultaneous read and write.**
  - Stimulus: with count = 2, assert i_wr_en and i_ack together for 10 cycles.
  - Required: o_count stays at 2 and FIFO order is preserved across the pointer wrap.
  - Stimulus: then, with the FIFO full, assert both together.
  - Required: count becomes 3 and o_overflow = 1.
- **Empty bypass.**
  - Stimulus: write 0x55 into an empty FIFO with FWFT = 1.
  - Required: on the next cycle o_empty_n = 1 and o_data = 0x55.
  - Stimulus: repeat with FWFT = 0 and pulse i_ack.
  - Required: o_data = 0x55 one cycle after i_ack.
- **Flush priority.**
  - Stimulus: with count = 3, assert i_flush, i_wr_en and i_ack in the same cycle.
  - Required: count = 0, o_empty = 1, and no error flag changes. A subsequent write of 0x77 reads back as 0x77.
- **Error clear and async reset.**
  - Stimulus: assert i_clr_err together with an overflow event.
  - Required: o_overflow stays 1. i_clr_err alone then clears it.
  - Stimulus: assert i_reset between clock edges.
  - Required: all outputs reach their reset values before the next edge.
